// File: rtl/spi_slave_fsm_if.sv
// ---------------------------------------------------------------------------
// spi_slave_fsm_if
//
// Purpose:
//   Bundles the control-side signals that pass between the SPI front end /
//   shift register and the sequencing FSM.
//
// Signals:
//   csN          conditioned chip select, active low          (to FSM)
//   sclkPosEdge  one-clk strobe per SCLK rising edge          (to FSM)
//   sclkNegEdge  one-clk strobe per SCLK falling edge         (to FSM)
//   rwBit        MSB of the shift register, 1 = read          (to FSM)
//   addrWe       pulse: latch shift register as address       (from FSM)
//   dmWe         pulse: write shift register to data memory   (from FSM)
//   srLoad       pulse: parallel-load the shift register      (from FSM)
//   misoBufe     level: enable the MISO output buffer         (from FSM)
//   frameErr     sticky aborted-frame flag                    (from FSM,
//                only present when SPI_FSM_FRAME_ERR_EN is defined)
//
// Modports:
//   master  the datapath / testbench side (drives csN, strobes, rwBit)
//   slave   the FSM side (drives the control pulses)
// ---------------------------------------------------------------------------
interface spi_slave_fsm_if;
    logic csN;
    logic sclkPosEdge;
    logic sclkNegEdge;
    logic rwBit;
    logic addrWe;
    logic dmWe;
    logic srLoad;
    logic misoBufe;
`ifdef SPI_FSM_FRAME_ERR_EN
    logic frameErr;

    modport master (
        output csN, sclkPosEdge, sclkNegEdge, rwBit,
        input  addrWe, dmWe, srLoad, misoBufe, frameErr
    );

    modport slave (
        input  csN, sclkPosEdge, sclkNegEdge, rwBit,
        output addrWe, dmWe, srLoad, misoBufe, frameErr
    );
`else
    modport master (
        output csN, sclkPosEdge, sclkNegEdge, rwBit,
        input  addrWe, dmWe, srLoad, misoBufe
    );

    modport slave (
        input  csN, sclkPosEdge, sclkNegEdge, rwBit,
        output addrWe, dmWe, srLoad, misoBufe
    );
`endif
endinterface

// File: rtl/spi_slave_fsm.sv
// ---------------------------------------------------------------------------
// spi_slave_fsm
//
// Purpose:
//   Sequencing controller for the SPI slave datapath. Counts SCLK edge
//   strobes while chip select is low and issues the control pulses that let
//   a single shift register serve an address phase followed by either a read
//   phase (parallel load, then shift out on MISO) or a write phase (shift in,
//   then store to data memory).
//
// Parameters:
//   width   bits per phase, equal to the shift register width
//
// Ports:
//   clk     system clock, all logic on the rising edge
//   resetN  asynchronous active-low reset
//   bus     spi_slave_fsm_if.slave: csN, sclkPosEdge, sclkNegEdge, rwBit in;
//           addrWe, dmWe, srLoad, misoBufe (and optionally frameErr) out
//
// Configuration:
//   SPI_FSM_FRAME_ERR_EN  when defined, adds bus.frameErr, a sticky flag set
//                         when chip select rises in the middle of a counting
//                         phase and cleared when the next frame starts.
// ---------------------------------------------------------------------------
module spi_slave_fsm #(
    parameter int width = 8
) (
    input  logic           clk,
    input  logic           resetN,
    spi_slave_fsm_if.slave bus
);

    localparam int CNT_W = $clog2(width + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(width);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_LOAD,
        READ_SHIFT,
        WRITE_RECV,
        WRITE_STORE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;
    logic             count_strobe;

    logic addr_we_q,   addr_we_d;
    logic dm_we_q,     dm_we_d;
    logic sr_load_q,   sr_load_d;
    logic miso_bufe_q, miso_bufe_d;

    // Saturating increment; the counter never wraps past width.
    assign count_inc = (count_q == CNT_FULL) ? count_q : (count_q + CNT_ONE);

    // Next-state and counter logic. A phase completes in the same clk that
    // the width-th counted strobe arrives, so the owning pulse state is
    // entered on the very next clk. A chip-select rise outside IDLE wins
    // over everything else and suppresses any pulse that would have issued.
    always_comb begin
        state_d      = state_q;
        count_strobe = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.csN) begin
                    state_d = GET_ADDR;
                end
            end
            GET_ADDR: begin
                count_strobe = bus.sclkPosEdge;
                if (count_strobe && (count_inc == CNT_FULL)) begin
                    state_d = GOT_ADDR;
                end
            end
            GOT_ADDR: begin
                state_d = bus.rwBit ? READ_LOAD : WRITE_RECV;
            end
            READ_LOAD: begin
                state_d = READ_SHIFT;
            end
            READ_SHIFT: begin
                count_strobe = bus.sclkNegEdge;
                if (count_strobe && (count_inc == CNT_FULL)) begin
                    state_d = DONE;
                end
            end
            WRITE_RECV: begin
                count_strobe = bus.sclkPosEdge;
                if (count_strobe && (count_inc == CNT_FULL)) begin
                    state_d = WRITE_STORE;
                end
            end
            WRITE_STORE: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && bus.csN) begin
            state_d = IDLE;
        end

        // The counter restarts from zero on every state entry.
        if (state_d != state_q) begin
            count_d = '0;
        end else if (count_strobe) begin
            count_d = count_inc;
        end else begin
            count_d = count_q;
        end
    end

    // Outputs are decoded from the next state and registered, so each one is
    // high for exactly the clk cycles spent in its owning state.
    always_comb begin
        addr_we_d   = (state_d == GOT_ADDR);
        dm_we_d     = (state_d == WRITE_STORE);
        sr_load_d   = (state_d == READ_LOAD);
        miso_bufe_d = (state_d == READ_SHIFT);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            count_q     <= '0;
            addr_we_q   <= 1'b0;
            dm_we_q     <= 1'b0;
            sr_load_q   <= 1'b0;
            miso_bufe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_we_q   <= addr_we_d;
            dm_we_q     <= dm_we_d;
            sr_load_q   <= sr_load_d;
            miso_bufe_q <= miso_bufe_d;
        end
    end

    assign bus.addrWe   = addr_we_q;
    assign bus.dmWe     = dm_we_q;
    assign bus.srLoad   = sr_load_q;
    assign bus.misoBufe = miso_bufe_q;

`ifdef SPI_FSM_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    // Sticky aborted-frame flag. Starting a new frame (csN low in IDLE)
    // clears it; a csN rise part-way through a counting phase sets it.
    always_comb begin
        frame_err_d = frame_err_q;
        if ((state_q == IDLE) && !bus.csN) begin
            frame_err_d = 1'b0;
        end else if (bus.csN &&
                     ((state_q == GET_ADDR) ||
                      (state_q == WRITE_RECV) ||
                      (state_q == READ_SHIFT))) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.frameErr = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_fsm
//
// Purpose:
//   Directed testbench for spi_slave_fsm (width = 8). Each scenario task
//   drives strobes cycle by cycle and compares the packed output vector
//   {addrWe, dmWe, srLoad, misoBufe} against hand-computed values. When
//   SPI_FSM_FRAME_ERR_EN is defined the frameErr flag is checked as well.
// ---------------------------------------------------------------------------
module tb_spi_slave_fsm;

    logic clk;
    logic resetN;

    int assert_count;
    int fail_count;

    spi_slave_fsm_if bus_if ();

    spi_slave_fsm #(
        .width(8)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus_if)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed view of the four control outputs: {addrWe, dmWe, srLoad, misoBufe}.
    function automatic logic [3:0] read_outputs();
        return {bus_if.addrWe, bus_if.dmWe, bus_if.srLoad, bus_if.misoBufe};
    endfunction

    // Holds the given strobes for one clk, then returns 1 time unit after the
    // rising edge with the strobes cleared, ready for sampling.
    task automatic apply_stimulus(input logic pos, input logic neg);
        bus_if.sclkPosEdge = pos;
        bus_if.sclkNegEdge = neg;
        @(posedge clk);
        #1;
        bus_if.sclkPosEdge = 1'b0;
        bus_if.sclkNegEdge = 1'b0;
    endtask

    task automatic test_reset();
        resetN             = 1'b0;
        bus_if.csN         = 1'b1;
        bus_if.sclkPosEdge = 1'b0;
        bus_if.sclkNegEdge = 1'b0;
        bus_if.rwBit       = 1'b0;
        #2;
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL reset_outputs: observed %b, required %b", read_outputs(), 4'b0000);
        end
`ifdef SPI_FSM_FRAME_ERR_EN
        assert_count++;
        if (bus_if.frameErr !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_frame_err: observed %b, required %b", bus_if.frameErr, 1'b0);
        end
`endif
        // Activity during reset must not move the FSM.
        bus_if.csN = 1'b0;
        repeat (3) apply_stimulus(1'b1, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL reset_hold: observed %b, required %b", read_outputs(), 4'b0000);
        end
        bus_if.csN = 1'b1;
        resetN     = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL reset_release: observed %b, required %b", read_outputs(), 4'b0000);
        end
    endtask

    task automatic test_write();
        logic [3:0] seen;
        bus_if.csN   = 1'b0;
        bus_if.rwBit = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        seen = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b1, 1'b0);
            seen |= read_outputs();
        end
        assert_count++;
        if (seen !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL write_addr_early: observed %b, required %b", seen, 4'b0000);
        end
        apply_stimulus(1'b1, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b1000) begin
            fail_count++;
            $display("[TB] FAIL write_addr_we: observed %b, required %b", read_outputs(), 4'b1000);
        end
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL write_recv_enter: observed %b, required %b", read_outputs(), 4'b0000);
        end
        seen = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b1, 1'b0);
            seen |= read_outputs();
        end
        assert_count++;
        if (seen !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL write_data_early: observed %b, required %b", seen, 4'b0000);
        end
        apply_stimulus(1'b1, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0100) begin
            fail_count++;
            $display("[TB] FAIL write_dm_we: observed %b, required %b", read_outputs(), 4'b0100);
        end
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL write_done: observed %b, required %b", read_outputs(), 4'b0000);
        end
        bus_if.csN = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL write_idle: observed %b, required %b", read_outputs(), 4'b0000);
        end
    endtask

    task automatic test_read();
        logic [3:0] seen;
        bus_if.csN   = 1'b0;
        bus_if.rwBit = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        repeat (7) apply_stimulus(1'b1, 1'b0);
        bus_if.rwBit = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b1000) begin
            fail_count++;
            $display("[TB] FAIL read_addr_we: observed %b, required %b", read_outputs(), 4'b1000);
        end
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0010) begin
            fail_count++;
            $display("[TB] FAIL read_sr_load: observed %b, required %b", read_outputs(), 4'b0010);
        end
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0001) begin
            fail_count++;
            $display("[TB] FAIL read_bufe_on: observed %b, required %b", read_outputs(), 4'b0001);
        end
        // A rising edge during the read phase must not advance the count.
        apply_stimulus(1'b1, 1'b0);
        seen = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b0, 1'b1);
            seen &= read_outputs();
        end
        assert_count++;
        if (seen !== 4'b0001) begin
            fail_count++;
            $display("[TB] FAIL read_bufe_hold: observed %b, required %b", seen, 4'b0001);
        end
        apply_stimulus(1'b0, 1'b1);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL read_bufe_off: observed %b, required %b", read_outputs(), 4'b0000);
        end
        bus_if.rwBit = 1'b0;
        bus_if.csN   = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL read_idle: observed %b, required %b", read_outputs(), 4'b0000);
        end
`ifdef SPI_FSM_FRAME_ERR_EN
        assert_count++;
        if (bus_if.frameErr !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL read_frame_err: observed %b, required %b", bus_if.frameErr, 1'b0);
        end
`endif
    endtask

    task automatic test_abort();
        bus_if.csN   = 1'b0;
        bus_if.rwBit = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        repeat (8) apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        repeat (4) apply_stimulus(1'b1, 1'b0);
        bus_if.csN = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL abort_idle: observed %b, required %b", read_outputs(), 4'b0000);
        end
`ifdef SPI_FSM_FRAME_ERR_EN
        assert_count++;
        if (bus_if.frameErr !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL abort_frame_err_set: observed %b, required %b", bus_if.frameErr, 1'b1);
        end
`endif
        apply_stimulus(1'b1, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL abort_no_dm_we: observed %b, required %b", read_outputs(), 4'b0000);
        end
`ifdef SPI_FSM_FRAME_ERR_EN
        assert_count++;
        if (bus_if.frameErr !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL abort_frame_err_hold: observed %b, required %b", bus_if.frameErr, 1'b1);
        end
`endif
        // A fresh frame must start from IDLE with a full address phase.
        bus_if.csN = 1'b0;
        apply_stimulus(1'b0, 1'b0);
`ifdef SPI_FSM_FRAME_ERR_EN
        assert_count++;
        if (bus_if.frameErr !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL abort_frame_err_clear: observed %b, required %b", bus_if.frameErr, 1'b0);
        end
`endif
        repeat (7) apply_stimulus(1'b1, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL abort_restart_7: observed %b, required %b", read_outputs(), 4'b0000);
        end
        apply_stimulus(1'b1, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b1000) begin
            fail_count++;
            $display("[TB] FAIL abort_restart_addr_we: observed %b, required %b", read_outputs(), 4'b1000);
        end
        // Rising csN in GOT_ADDR is not a counting phase, so no frame error.
        bus_if.csN = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL abort_got_addr_exit: observed %b, required %b", read_outputs(), 4'b0000);
        end
`ifdef SPI_FSM_FRAME_ERR_EN
        assert_count++;
        if (bus_if.frameErr !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL abort_got_addr_frame_err: observed %b, required %b", bus_if.frameErr, 1'b0);
        end
`endif
    endtask

    task automatic test_reset_mid_read();
        bus_if.csN   = 1'b0;
        bus_if.rwBit = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        repeat (7) apply_stimulus(1'b1, 1'b0);
        bus_if.rwBit = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        assert_count++;
        if (read_outputs() !== 4'b0001) begin
            fail_count++;
            $display("[TB] FAIL midread_bufe_on: observed %b, required %b", read_outputs(), 4'b0001);
        end
        // Assert reset between clock edges; outputs must drop without a clk.
        #1;
        resetN = 1'b0;
        #1;
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL midread_async_reset: observed %b, required %b", read_outputs(), 4'b0000);
        end
        bus_if.csN   = 1'b1;
        bus_if.rwBit = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL midread_post_reset: observed %b, required %b", read_outputs(), 4'b0000);
        end
`ifdef SPI_FSM_FRAME_ERR_EN
        assert_count++;
        if (bus_if.frameErr !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL midread_frame_err: observed %b, required %b", bus_if.frameErr, 1'b0);
        end
`endif
        test_write();
    endtask

    task automatic test_extra_edges();
        logic [3:0] seen;
        bus_if.csN   = 1'b0;
        bus_if.rwBit = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        repeat (8) apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        repeat (8) apply_stimulus(1'b1, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0100) begin
            fail_count++;
            $display("[TB] FAIL extra_dm_we: observed %b, required %b", read_outputs(), 4'b0100);
        end
        // DONE: three extra rising edges, then a full phase worth of both edges.
        seen = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0);
            seen |= read_outputs();
        end
        assert_count++;
        if (seen !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL extra_pos_3: observed %b, required %b", seen, 4'b0000);
        end
        seen = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b0);
            seen |= read_outputs();
            apply_stimulus(1'b0, 1'b1);
            seen |= read_outputs();
        end
        assert_count++;
        if (seen !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL extra_no_wrap: observed %b, required %b", seen, 4'b0000);
        end
        bus_if.csN = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL extra_idle: observed %b, required %b", read_outputs(), 4'b0000);
        end
    endtask

    task automatic test_coincident();
        bus_if.csN   = 1'b0;
        bus_if.rwBit = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        repeat (8) apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        repeat (7) apply_stimulus(1'b1, 1'b0);
        bus_if.csN = 1'b1;
        apply_stimulus(1'b1, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL coinc_no_dm_we: observed %b, required %b", read_outputs(), 4'b0000);
        end
`ifdef SPI_FSM_FRAME_ERR_EN
        assert_count++;
        if (bus_if.frameErr !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL coinc_frame_err: observed %b, required %b", bus_if.frameErr, 1'b1);
        end
`endif
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL coinc_after: observed %b, required %b", read_outputs(), 4'b0000);
        end
        // csN falls together with a rising edge: that edge is not counted.
        bus_if.csN = 1'b0;
        apply_stimulus(1'b1, 1'b0);
        repeat (7) apply_stimulus(1'b1, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL coinc_fall_edge_uncounted: observed %b, required %b", read_outputs(), 4'b0000);
        end
        apply_stimulus(1'b1, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b1000) begin
            fail_count++;
            $display("[TB] FAIL coinc_fall_addr_we: observed %b, required %b", read_outputs(), 4'b1000);
        end
        bus_if.csN = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        assert_count++;
        if (read_outputs() !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL coinc_final_idle: observed %b, required %b", read_outputs(), 4'b0000);
        end
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_reset_mid_read();
        test_extra_edges();
        test_coincident();
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
